// File: rtl/mpu_matrix_loader_if.sv
// Operand-side bus of the MPU matrix loader: element stream in, matrix pair out.
// The slave modport is the loader's view; the master modport is its producer/consumer.
interface mpu_matrix_loader_if #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8
);
  localparam int N     = DIM * DIM;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic                  flush;
  logic [ELEM_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ELEM_W*N-1:0]   matrix_a;
  logic [ELEM_W*N-1:0]   matrix_b;
  logic                  out_valid;
  logic                  out_ready;
  logic                  loading_b;
  logic [IDX_W-1:0]      elem_idx;

  modport slave (
    input  flush, in_data, in_valid, out_ready,
    output in_ready, matrix_a, matrix_b, out_valid, loading_b, elem_idx
  );

  modport master (
    output flush, in_data, in_valid, out_ready,
    input  in_ready, matrix_a, matrix_b, out_valid, loading_b, elem_idx
  );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Assembles two flattened DIMxDIM operand matrices (A then B) from a byte stream
// and holds the pair stable for the element-wise adder until it is accepted.
module mpu_matrix_loader #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mpu_matrix_loader_if.slave    bus
);
  localparam int N     = DIM * DIM;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_a, wr_b;
  logic                last_slot;
  logic [ELEM_W*N-1:0] mat_a_q, mat_b_q;

  assign last_slot = (idx_q == IDX_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // in_ready is high in both load states, so an accept reduces to in_valid there
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    if (bus.flush) begin
      state_d = LOAD_A;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (bus.in_valid) begin
            wr_a = 1'b1;
            if (last_slot) begin
              idx_d   = '0;
              state_d = LOAD_B;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (bus.in_valid) begin
            wr_b = 1'b1;
            if (last_slot) begin
              idx_d   = '0;
              state_d = HOLD;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = LOAD_A;
          end
        end
        default: begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Contents survive flush and transfers; only reset zeroes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else begin
      if (wr_a) begin
        mat_a_q[ELEM_W*idx_q +: ELEM_W] <= bus.in_data;
      end
      if (wr_b) begin
        mat_b_q[ELEM_W*idx_q +: ELEM_W] <= bus.in_data;
      end
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.loading_b = (state_q == LOAD_B);
  assign bus.elem_idx  = idx_q;
  assign bus.matrix_a  = mat_a_q;
  assign bus.matrix_b  = mat_b_q;
endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed self-checking bench for mpu_matrix_loader: basic load, backpressure,
// bursty input, flush, asynchronous reset and back-to-back transfers.
module tb_mpu_matrix_loader;
  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int N      = DIM * DIM;
  localparam int MW     = ELEM_W * N;

  typedef logic [7:0] byteq_t[$];

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   expIdx   = 0;

  mpu_matrix_loader_if #(.DIM(DIM), .ELEM_W(ELEM_W)) bus ();

  mpu_matrix_loader #(.DIM(DIM), .ELEM_W(ELEM_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic byteq_t makeSeq(input int start, input int step);
    byteq_t q;
    for (int k = 0; k < N; k++) q.push_back(8'(start + step * k));
    return q;
  endfunction

  function automatic logic [MW-1:0] packMatrix(input byteq_t q);
    logic [MW-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) m[8*k +: 8] = q[k];
    return m;
  endfunction

  // Streams a list of elements with up to maxGap idle cycles before each one
  task automatic feedElems(input byteq_t vals, input int maxGap, input logic ordy);
    int gaps;
    for (int i = 0; i < vals.size(); i++) begin
      gaps = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      repeat (gaps) begin
        applyStimulus(1'b0, 8'h00, ordy, 1'b0);
        checkOutput("gap_idx", 256'(bus.elem_idx), 256'(expIdx));
      end
      checkOutput("load_in_ready", 256'(bus.in_ready), 256'(1));
      applyStimulus(1'b1, vals[i], ordy, 1'b0);
      expIdx = (expIdx + 1) % N;
      checkOutput("acc_idx", 256'(bus.elem_idx), 256'(expIdx));
    end
  endtask

  task automatic releaseHold(input string tag);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput({tag, "_out_valid_low"}, 256'(bus.out_valid), 256'(0));
    checkOutput({tag, "_in_ready_high"}, 256'(bus.in_ready), 256'(1));
    checkOutput({tag, "_loading_b_low"}, 256'(bus.loading_b), 256'(0));
  endtask

  task automatic checkPair(input string tag, input byteq_t a, input byteq_t b);
    checkOutput({tag, "_out_valid"}, 256'(bus.out_valid), 256'(1));
    checkOutput({tag, "_in_ready"}, 256'(bus.in_ready), 256'(0));
    checkOutput({tag, "_matrix_a"}, 256'(bus.matrix_a), 256'(packMatrix(a)));
    checkOutput({tag, "_matrix_b"}, 256'(bus.matrix_b), 256'(packMatrix(b)));
  endtask

  initial begin
    byteq_t seqA, seqB, seqC;
    logic [MW-1:0] sumVec, sumExp;
    logic [MW-1:0] heldA, heldB;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #12;
    checkOutput("rst_in_ready", 256'(bus.in_ready), 256'(1));
    checkOutput("rst_out_valid", 256'(bus.out_valid), 256'(0));
    checkOutput("rst_loading_b", 256'(bus.loading_b), 256'(0));
    checkOutput("rst_elem_idx", 256'(bus.elem_idx), 256'(0));
    checkOutput("rst_matrix_a", 256'(bus.matrix_a), 256'(0));
    checkOutput("rst_matrix_b", 256'(bus.matrix_b), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic load: A = 1..25, B = 25..1
    seqA = makeSeq(1, 1);
    seqB = makeSeq(25, -1);
    feedElems(seqA, 0, 1'b0);
    checkOutput("basic_loading_b", 256'(bus.loading_b), 256'(1));
    feedElems(seqB, 0, 1'b0);
    checkPair("basic", seqA, seqB);
    checkOutput("basic_a_lo", 256'(bus.matrix_a[7:0]), 256'(8'd1));
    checkOutput("basic_a_hi", 256'(bus.matrix_a[199:192]), 256'(8'd25));
    checkOutput("basic_b_lo", 256'(bus.matrix_b[7:0]), 256'(8'd25));
    checkOutput("basic_b_hi", 256'(bus.matrix_b[199:192]), 256'(8'd1));
    for (int k = 0; k < N; k++) begin
      sumVec[8*k +: 8] = bus.matrix_a[8*k +: 8] + bus.matrix_b[8*k +: 8];
      sumExp[8*k +: 8] = 8'd26;
    end
    checkOutput("basic_sum", 256'(sumVec), 256'(sumExp));

    // Backpressure: HOLD ignores incoming elements while out_ready is low
    heldA = bus.matrix_a;
    heldB = bus.matrix_b;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
      checkOutput("bp_in_ready", 256'(bus.in_ready), 256'(0));
      checkOutput("bp_out_valid", 256'(bus.out_valid), 256'(1));
    end
    checkOutput("bp_matrix_a", 256'(bus.matrix_a), 256'(packMatrix(seqA)));
    checkOutput("bp_matrix_b", 256'(bus.matrix_b), 256'(packMatrix(seqB)));
    checkOutput("bp_elem_idx", 256'(bus.elem_idx), 256'(0));
    releaseHold("bp");
    checkOutput("bp_a_stable_after", 256'(bus.matrix_a), 256'(heldA));
    checkOutput("bp_b_stable_after", 256'(bus.matrix_b), 256'(heldB));

    // Bursty input: 0x10..0x28 for both matrices with random gaps
    seqC = makeSeq(8'h10, 1);
    feedElems(seqC, 3, 1'b0);
    feedElems(seqC, 3, 1'b0);
    checkPair("burst", seqC, seqC);
    releaseHold("burst");

    // Flush mid-B: 25 A elements, 7 B elements, then flush with a live element
    feedElems(makeSeq(8'h30, 1), 0, 1'b0);
    seqB = makeSeq(8'h60, 1);
    seqB = seqB[0:6];
    feedElems(seqB, 0, 1'b0);
    checkOutput("flush_pre_idx", 256'(bus.elem_idx), 256'(7));
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
    checkOutput("flush_elem_idx", 256'(bus.elem_idx), 256'(0));
    checkOutput("flush_loading_b", 256'(bus.loading_b), 256'(0));
    checkOutput("flush_in_ready", 256'(bus.in_ready), 256'(1));
    checkOutput("flush_out_valid", 256'(bus.out_valid), 256'(0));
    checkOutput("flush_dropped_slot7", 256'(bus.matrix_b[63:56]), 256'(8'h17));
    checkOutput("flush_kept_slot0", 256'(bus.matrix_b[7:0]), 256'(8'h60));
    expIdx = 0;
    seqA = makeSeq(8'h40, 1);
    seqB = makeSeq(8'h80, 1);
    feedElems(seqA, 0, 1'b0);
    feedElems(seqB, 0, 1'b0);
    checkPair("post_flush", seqA, seqB);
    releaseHold("post_flush");

    // Reset mid-load, asserted between clock edges
    seqA = makeSeq(1, 1);
    seqB = makeSeq(25, -1);
    seqC = seqA[0:11];
    feedElems(seqC, 0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_matrix_a", 256'(bus.matrix_a), 256'(0));
    checkOutput("arst_matrix_b", 256'(bus.matrix_b), 256'(0));
    checkOutput("arst_out_valid", 256'(bus.out_valid), 256'(0));
    checkOutput("arst_elem_idx", 256'(bus.elem_idx), 256'(0));
    checkOutput("arst_in_ready", 256'(bus.in_ready), 256'(1));
    @(negedge clk);
    rst_n = 1'b1;
    expIdx = 0;
    feedElems(seqA, 0, 1'b0);
    feedElems(seqB, 0, 1'b0);
    checkPair("post_rst", seqA, seqB);
    releaseHold("post_rst");

    // Back-to-back loads with out_ready tied high
    seqA = makeSeq(8'hA0, 1);
    seqB = makeSeq(8'h05, 2);
    feedElems(seqA, 0, 1'b1);
    feedElems(seqB, 0, 1'b1);
    checkPair("b2b_first", seqA, seqB);
    releaseHold("b2b_first");
    feedElems(seqB, 0, 1'b1);
    feedElems(seqA, 0, 1'b1);
    checkPair("b2b_second", seqB, seqA);
    releaseHold("b2b_second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
